// File: rtl/lc_line_responder.sv
// In-order L2 stand-in for the L1D line port: queues line reads/writes and serves them after a fixed latency.
// Define LC_RESP_WRITE_ACK_EN to make writes also return a response carrying the written data.
module lc_line_responder #(
  parameter int PADDR_BITS = 22,
  parameter int B          = 64,
  parameter int LINES      = 256,
  parameter int QDEPTH     = 4,
  parameter int LATENCY    = 4
) (
  input  logic                  clk_in,
  input  logic                  rst_N_in,
  input  logic                  req_valid_in,
  output logic                  req_ready_out,
  input  logic                  req_we_in,
  input  logic [PADDR_BITS-1:0] req_addr_in,
  input  logic [8*B-1:0]        req_value_in,
  output logic                  resp_valid_out,
  input  logic                  resp_ready_in,
  output logic [PADDR_BITS-1:0] resp_addr_out,
  output logic [8*B-1:0]        resp_value_out
);

  localparam int DW    = 8 * B;
  localparam int OFF_W = $clog2(B);
  localparam int IDX_W = $clog2(LINES);
  localparam int PTR_W = $clog2(QDEPTH);
  localparam int CNT_W = (LATENCY > 1) ? $clog2(LATENCY) : 1;

`ifdef LC_RESP_WRITE_ACK_EN
  localparam logic WR_ACK = 1'b1;
`else
  localparam logic WR_ACK = 1'b0;
`endif

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_RESP = 2'd2
  } state_e;

  state_e                  state_q, state_d;

  logic                    q_we_q    [QDEPTH];
  logic [PADDR_BITS-1:0]   q_addr_q  [QDEPTH];
  logic [DW-1:0]           q_value_q [QDEPTH];
  logic [PTR_W:0]          wr_ptr_q, wr_ptr_d;
  logic [PTR_W:0]          rd_ptr_q, rd_ptr_d;
  logic                    ready_q, ready_d;

  logic                    cur_we_q;
  logic [PADDR_BITS-1:0]   cur_addr_q;
  logic [DW-1:0]           cur_value_q;
  logic [CNT_W-1:0]        cnt_q, cnt_d;

  logic [DW-1:0]           line_ram_q [LINES];
  logic [LINES-1:0]        line_valid_q;

  logic                    resp_valid_q;
  logic [PADDR_BITS-1:0]   resp_addr_q;
  logic [DW-1:0]           resp_value_q;

  logic                    accept_s, empty_s, full_next_s, cnt_zero_s;
  logic                    latch_s, commit_s, load_resp_s, pop_s;
  logic [IDX_W-1:0]        cur_idx_s;
  logic [DW-1:0]           line_rd_s;

  assign accept_s   = req_valid_in && ready_q;
  assign empty_s    = (wr_ptr_q == rd_ptr_q);
  assign cnt_zero_s = (cnt_q == {CNT_W{1'b0}});
  assign cur_idx_s  = cur_addr_q[OFF_W +: IDX_W];
  assign line_rd_s  = line_valid_q[cur_idx_s] ? line_ram_q[cur_idx_s] : {DW{1'b0}};

  // Ready is computed from post-edge occupancy, so a pop never opens a slot in the same cycle.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (accept_s) begin
      wr_ptr_d = wr_ptr_q + {{PTR_W{1'b0}}, 1'b1};
    end else begin
      wr_ptr_d = wr_ptr_q;
    end
    if (pop_s) begin
      rd_ptr_d = rd_ptr_q + {{PTR_W{1'b0}}, 1'b1};
    end else begin
      rd_ptr_d = rd_ptr_q;
    end
    full_next_s = (wr_ptr_d[PTR_W] != rd_ptr_d[PTR_W]) &&
                  (wr_ptr_d[PTR_W-1:0] == rd_ptr_d[PTR_W-1:0]);
    ready_d     = !full_next_s;
  end

  always_ff @(posedge clk_in) begin
    if (accept_s) begin
      q_we_q[wr_ptr_q[PTR_W-1:0]]    <= req_we_in;
      q_addr_q[wr_ptr_q[PTR_W-1:0]]  <= req_addr_in;
      q_value_q[wr_ptr_q[PTR_W-1:0]] <= req_value_in;
    end
  end

  always_ff @(posedge clk_in or negedge rst_N_in) begin
    if (!rst_N_in) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (!empty_s) state_d = ST_WAIT;
        else          state_d = ST_IDLE;
      end
      ST_WAIT: begin
        if (!cnt_zero_s)              state_d = ST_WAIT;
        else if (cur_we_q && !WR_ACK) state_d = ST_IDLE;
        else                          state_d = ST_RESP;
      end
      ST_RESP: begin
        if (resp_ready_in) state_d = ST_IDLE;
        else               state_d = ST_RESP;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    latch_s     = 1'b0;
    commit_s    = 1'b0;
    load_resp_s = 1'b0;
    pop_s       = 1'b0;
    cnt_d       = cnt_q;
    case (state_q)
      ST_IDLE: begin
        latch_s = !empty_s;
        if (!empty_s) cnt_d = CNT_W'(LATENCY - 1);
        else          cnt_d = cnt_q;
      end
      ST_WAIT: begin
        if (cnt_zero_s) begin
          commit_s    = cur_we_q;
          load_resp_s = !cur_we_q || WR_ACK;
          pop_s       = cur_we_q && !WR_ACK;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      ST_RESP: begin
        pop_s = resp_ready_in;
      end
      default: begin
        cnt_d = cnt_q;
      end
    endcase
  end

  // Read data is taken from the line store at WAIT completion, after all older writes committed.
  always_ff @(posedge clk_in or negedge rst_N_in) begin
    if (!rst_N_in) begin
      wr_ptr_q     <= {(PTR_W+1){1'b0}};
      rd_ptr_q     <= {(PTR_W+1){1'b0}};
      ready_q      <= 1'b0;
      cnt_q        <= {CNT_W{1'b0}};
      cur_we_q     <= 1'b0;
      cur_addr_q   <= {PADDR_BITS{1'b0}};
      cur_value_q  <= {DW{1'b0}};
      line_valid_q <= {LINES{1'b0}};
      resp_valid_q <= 1'b0;
      resp_addr_q  <= {PADDR_BITS{1'b0}};
      resp_value_q <= {DW{1'b0}};
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      ready_q  <= ready_d;
      cnt_q    <= cnt_d;
      if (latch_s) begin
        cur_we_q    <= q_we_q[rd_ptr_q[PTR_W-1:0]];
        cur_addr_q  <= q_addr_q[rd_ptr_q[PTR_W-1:0]];
        cur_value_q <= q_value_q[rd_ptr_q[PTR_W-1:0]];
      end
      if (commit_s) begin
        line_valid_q[cur_idx_s] <= 1'b1;
      end
      if (load_resp_s) begin
        resp_valid_q <= 1'b1;
        resp_addr_q  <= cur_addr_q;
        resp_value_q <= cur_we_q ? cur_value_q : line_rd_s;
      end else if (resp_valid_q && resp_ready_in) begin
        resp_valid_q <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk_in) begin
    if (commit_s) begin
      line_ram_q[cur_idx_s] <= cur_value_q;
    end
  end

  assign req_ready_out  = ready_q;
  assign resp_valid_out = resp_valid_q;
  assign resp_addr_out  = resp_addr_q;
  assign resp_value_out = resp_value_q;

endmodule

// File: tb/tb_lc_line_responder.sv
// Self-checking bench for lc_line_responder: directed table, multi-cycle corner sequences and
// randomized traffic scored against an in-order line-memory model.
module tb_lc_line_responder;

  localparam int AW  = 22;
  localparam int DW  = 512;
  localparam int LAT = 4;

  logic          clk = 1'b0;
  logic          rst_N_in;
  logic          req_valid_in, req_ready_out, req_we_in;
  logic [AW-1:0] req_addr_in;
  logic [DW-1:0] req_value_in;
  logic          resp_valid_out, resp_ready_in;
  logic [AW-1:0] resp_addr_out;
  logic [DW-1:0] resp_value_out;

  int checks   = 0;
  int failures = 0;
  int accepted = 0;

  typedef struct {
    logic [AW-1:0] addr;
    logic [DW-1:0] val;
  } resp_t;

  resp_t         exp_q[$];
  logic [DW-1:0] mem_m [int];
  logic [DW-1:0] last_resp_val;

  lc_line_responder dut (
    .clk_in        (clk),
    .rst_N_in      (rst_N_in),
    .req_valid_in  (req_valid_in),
    .req_ready_out (req_ready_out),
    .req_we_in     (req_we_in),
    .req_addr_in   (req_addr_in),
    .req_value_in  (req_value_in),
    .resp_valid_out(resp_valid_out),
    .resp_ready_in (resp_ready_in),
    .resp_addr_out (resp_addr_out),
    .resp_value_out(resp_value_out)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
    end
  endtask

  function automatic int idx_of(input logic [AW-1:0] a);
    return (int'(a) / 64) % 256;
  endfunction

  function automatic logic [DW-1:0] rand_line();
    logic [DW-1:0] r;
    for (int i = 0; i < DW / 32; i++) r[i*32 +: 32] = $urandom();
    return r;
  endfunction

  // Scoreboard: program-order line memory; handshakes are seen at the negedge before the edge.
  always @(negedge clk) begin
    if (rst_N_in) begin
      if (req_valid_in && req_ready_out) begin
        accepted++;
        if (req_we_in) begin
          mem_m[idx_of(req_addr_in)] = req_value_in;
`ifdef LC_RESP_WRITE_ACK_EN
          exp_q.push_back('{req_addr_in, req_value_in});
`endif
        end else begin
          exp_q.push_back('{req_addr_in, mem_m.exists(idx_of(req_addr_in)) ?
                            mem_m[idx_of(req_addr_in)] : {DW{1'b0}}});
        end
      end
      if (resp_valid_out && resp_ready_in) begin
        last_resp_val = resp_value_out;
        if (exp_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL sb_unexpected_resp actual addr=%0h required=none", resp_addr_out);
        end else begin
          resp_t r;
          r = exp_q.pop_front();
          chk("sb_addr", DW'(resp_addr_out), DW'(r.addr));
          chk("sb_value", resp_value_out, r.val);
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic we, input logic [AW-1:0] a, input logic [DW-1:0] d);
    int n;
    n = 0;
    req_valid_in = 1'b1;
    req_we_in    = we;
    req_addr_in  = a;
    req_value_in = d;
    while (!req_ready_out && n < 200) begin
      tick();
      n++;
    end
    if (n >= 200) begin
      checks++;
      failures++;
      $display("FAIL send_timeout actual=ready_low required=accept addr=%0h", a);
    end
    tick();
    req_valid_in = 1'b0;
  endtask

  task automatic wait_resp(input string nm, output int k);
    k = 0;
    while (!resp_valid_out && k < 50) begin
      tick();
      k++;
    end
    chk({nm, "_lat"}, DW'(k), DW'(LAT + 1));
  endtask

  task automatic read_check(input string nm, input logic [AW-1:0] a, input logic [DW-1:0] e);
    int k;
    send(1'b0, a, {DW{1'b0}});
    wait_resp(nm, k);
    chk({nm, "_addr"}, DW'(resp_addr_out), DW'(a));
    chk({nm, "_value"}, resp_value_out, e);
    tick();
  endtask

  task automatic write_line(input string nm, input logic [AW-1:0] a, input logic [DW-1:0] d);
`ifdef LC_RESP_WRITE_ACK_EN
    int k;
    send(1'b1, a, d);
    wait_resp(nm, k);
    chk({nm, "_ack_addr"}, DW'(resp_addr_out), DW'(a));
    chk({nm, "_ack_value"}, resp_value_out, d);
    tick();
`else
    send(1'b1, a, d);
    repeat (LAT + 3) tick();
`endif
  endtask

  task automatic drain(input string nm);
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 2000) begin
      tick();
      n++;
    end
    chk({nm, "_drained"}, DW'(exp_q.size()), DW'(0));
    repeat (40) tick();
  endtask

  typedef struct {
    logic          we;
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
    string         nm;
  } vec_t;

  vec_t          tbl[9];
  logic [AW-1:0] a4[5];
  logic [DW-1:0] cap_v, d5, pat;
  logic [AW-1:0] cap_a;
  int            k, acc0;
  logic          stable, blocked;

  initial begin
    rst_N_in      = 1'b0;
    req_valid_in  = 1'b0;
    req_we_in     = 1'b0;
    req_addr_in   = {AW{1'b0}};
    req_value_in  = {DW{1'b0}};
    resp_ready_in = 1'b1;
    last_resp_val = {DW{1'b0}};

    repeat (3) tick();
    chk("rst_ready", DW'(req_ready_out), DW'(0));
    chk("rst_valid", DW'(resp_valid_out), DW'(0));
    chk("rst_addr", DW'(resp_addr_out), DW'(0));
    chk("rst_value", resp_value_out, {DW{1'b0}});
    #2 rst_N_in = 1'b1;
    chk("rel_ready_before_edge", DW'(req_ready_out), DW'(0));
    tick();
    chk("rel_ready_after_edge", DW'(req_ready_out), DW'(1));

    read_check("t1", 22'h002000, {DW{1'b0}});

    pat = {16{32'hA5A5_0F0F}};
    tbl[0] = '{1'b1, 22'h060300, 512'hDEADBEEF, "w60300"};
    tbl[1] = '{1'b0, 22'h060300, 512'hDEADBEEF, "r60300"};
    tbl[2] = '{1'b1, 22'h005000, 512'h1234_5678_9ABC, "w5000"};
    tbl[3] = '{1'b0, 22'h005000, 512'h1234_5678_9ABC, "r5000"};
    tbl[4] = '{1'b0, 22'h009000, 512'h1234_5678_9ABC, "r9000_alias"};
    tbl[5] = '{1'b0, 22'h005010, 512'h1234_5678_9ABC, "r5010_offset"};
    tbl[6] = '{1'b0, 22'h005040, 512'h0, "r5040_empty"};
    tbl[7] = '{1'b1, 22'h009000, pat, "w9000_alias"};
    tbl[8] = '{1'b0, 22'h005000, pat, "r5000_new"};
    for (int i = 0; i < 9; i++) begin
      if (tbl[i].we) write_line(tbl[i].nm, tbl[i].addr, tbl[i].data);
      else           read_check(tbl[i].nm, tbl[i].addr, tbl[i].data);
    end

    // Back-pressured response must hold its payload until accepted.
    resp_ready_in = 1'b0;
    send(1'b0, 22'h004040, {DW{1'b0}});
    wait_resp("t3", k);
    cap_a = resp_addr_out;
    cap_v = resp_value_out;
    chk("t3_addr", DW'(cap_a), DW'(22'h004040));
    chk("t3_value", cap_v, {DW{1'b0}});
    stable = 1'b1;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (!(resp_valid_out && resp_addr_out == cap_a && resp_value_out == cap_v)) stable = 1'b0;
    end
    chk("t3_hold", DW'(stable), DW'(1));
    resp_ready_in = 1'b1;
    tick();
    chk("t3_drop", DW'(resp_valid_out), DW'(0));

    // Queue fills at QDEPTH while the head waits in RESP.
    resp_ready_in = 1'b0;
    a4[0] = 22'h005000; a4[1] = 22'h005040; a4[2] = 22'h007000;
    a4[3] = 22'h009000; a4[4] = 22'h00F000;
    acc0 = accepted;
    for (int i = 0; i < 4; i++) send(1'b0, a4[i], {DW{1'b0}});
    chk("t4_ready_full", DW'(req_ready_out), DW'(0));
    req_valid_in = 1'b1;
    req_we_in    = 1'b0;
    req_addr_in  = a4[4];
    blocked = 1'b1;
    for (int i = 0; i < 12; i++) begin
      tick();
      if (req_ready_out) blocked = 1'b0;
    end
    chk("t4_ready_stays_low", DW'(blocked), DW'(1));
    chk("t4_accepted", DW'(accepted - acc0), DW'(4));
    resp_ready_in = 1'b1;
    send(1'b0, a4[4], {DW{1'b0}});
    drain("t4");

    d5 = rand_line();
    send(1'b1, 22'h005000, d5);
    send(1'b0, 22'h005000, {DW{1'b0}});
    drain("t5");
    chk("t5_raw", last_resp_val, d5);

    // Reset asserted mid-WAIT and again with a response pending.
    send(1'b0, 22'h060300, {DW{1'b0}});
    tick();
    tick();
    rst_N_in = 1'b0;
    exp_q.delete();
    mem_m.delete();
    #1;
    chk("t6_valid_wait_rst", DW'(resp_valid_out), DW'(0));
    chk("t6_ready_rst", DW'(req_ready_out), DW'(0));
    #3 rst_N_in = 1'b1;
    tick();
    resp_ready_in = 1'b0;
    send(1'b0, 22'h002000, {DW{1'b0}});
    wait_resp("t6_pre", k);
    #2 rst_N_in = 1'b0;
    exp_q.delete();
    mem_m.delete();
    #1;
    chk("t6_valid_resp_rst", DW'(resp_valid_out), DW'(0));
    chk("t6_addr_resp_rst", DW'(resp_addr_out), DW'(0));
    #3 rst_N_in = 1'b1;
    resp_ready_in = 1'b1;
    tick();
    read_check("t6_rd", 22'h060300, {DW{1'b0}});
`ifdef LC_RESP_WRITE_ACK_EN
    write_line("t6_ack", 22'h001000, rand_line());
`endif

    for (int c = 0; c < 400; c++) begin
      req_valid_in  = ($urandom_range(0, 1) == 1);
      req_we_in     = ($urandom_range(0, 2) == 0);
      req_addr_in   = {8'($urandom_range(0, 255)), 8'($urandom_range(0, 3)), 6'($urandom_range(0, 63))};
      req_value_in  = rand_line();
      resp_ready_in = ($urandom_range(0, 3) != 0);
      tick();
    end
    req_valid_in  = 1'b0;
    resp_ready_in = 1'b1;
    drain("rand");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    failures++;
    $display("FAIL watchdog actual=timeout required=finish");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
